// File: rtl/fpdiv_issue_if.sv
// Handshake and divider bus bundle for fpdiv_issue.
// slave is the issue block's view; master is the requester/consumer/divider side.
interface fpdiv_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_n;
  logic [31:0] in_d;
  logic        in_rm;
  logic [1:0]  in_op;

  logic [31:0] div_n;
  logic [31:0] div_d;
  logic        div_rm;
  logic [1:0]  div_op;
  logic [31:0] div_result;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_dz;
  logic        out_nv;

  modport slave (
    input  in_valid, in_n, in_d, in_rm, in_op, div_result, out_ready,
    output in_ready, div_n, div_d, div_rm, div_op, out_valid, out_result, out_dz, out_nv
  );

  modport master (
    output in_valid, in_n, in_d, in_rm, in_op, div_result, out_ready,
    input  in_ready, div_n, div_d, div_rm, div_op, out_valid, out_result, out_dz, out_nv
  );
endinterface

// File: rtl/fpdiv_issue.sv
// Issue/hold wrapper around a fixed-latency f32 divider.
// Accepts one request at a time, holds operands toward the divider, waits
// LATENCY cycles and presents the quotient until the consumer takes it.
// Optional macro FPDIV_SPECIAL_EN adds IEEE special-case detection that
// bypasses the divider (NaN/zero/infinity operands) and raises dz/nv flags.
module fpdiv_issue #(
  parameter int unsigned LATENCY = 12
) (
  input logic          clk,
  input logic          reset,
  fpdiv_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [31:0] hold_n;
  logic [31:0] hold_d;
  logic        hold_rm;
  logic [1:0]  hold_op;
  logic [31:0] result_r;
  logic        dz_r;
  logic        nv_r;
  logic        in_ready;
  logic        out_valid;
  logic        accept;
  logic        special;
  logic [31:0] spec_result;
  logic        spec_dz;
  logic        spec_nv;

  assign accept = bus.in_valid && in_ready;

`ifdef FPDIV_SPECIAL_EN
  logic       n_zero, n_inf, n_nan;
  logic       d_zero, d_inf, d_nan;
  logic       q_sign;

  // Classify operands; exponent 0 is treated as zero whatever the mantissa.
  always_comb begin
    n_zero      = (bus.in_n[30:23] == 8'h00);
    n_inf       = (bus.in_n[30:23] == 8'hFF) && (bus.in_n[22:0] == 23'd0);
    n_nan       = (bus.in_n[30:23] == 8'hFF) && (bus.in_n[22:0] != 23'd0);
    d_zero      = (bus.in_d[30:23] == 8'h00);
    d_inf       = (bus.in_d[30:23] == 8'hFF) && (bus.in_d[22:0] == 23'd0);
    d_nan       = (bus.in_d[30:23] == 8'hFF) && (bus.in_d[22:0] != 23'd0);
    q_sign      = bus.in_n[31] ^ bus.in_d[31];
    special     = 1'b1;
    spec_result = 32'h7FC00000;
    spec_dz     = 1'b0;
    spec_nv     = 1'b0;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      spec_nv = 1'b1;
    end else if (d_zero && !n_inf) begin
      spec_result = {q_sign, 8'hFF, 23'd0};
      spec_dz     = 1'b1;
    end else if (n_inf) begin
      spec_result = {q_sign, 8'hFF, 23'd0};
    end else if (n_zero || d_inf) begin
      spec_result = {q_sign, 31'd0};
    end else begin
      special     = 1'b0;
      spec_result = 32'd0;
    end
  end
`else
  assign special     = 1'b0;
  assign spec_result = 32'd0;
  assign spec_dz     = 1'b0;
  assign spec_nv     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = special ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == 8'd0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand hold, latency counter and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= 8'd0;
      hold_n   <= 32'd0;
      hold_d   <= 32'd0;
      hold_rm  <= 1'b0;
      hold_op  <= 2'd0;
      result_r <= 32'd0;
      dz_r     <= 1'b0;
      nv_r     <= 1'b0;
    end else if (accept) begin
      hold_n  <= bus.in_n;
      hold_d  <= bus.in_d;
      hold_rm <= bus.in_rm;
      hold_op <= bus.in_op;
      cnt     <= CNT_LOAD;
      if (special) begin
        result_r <= spec_result;
        dz_r     <= spec_dz;
        nv_r     <= spec_nv;
      end
    end else if (state == WAIT) begin
      if (cnt == 8'd0) begin
        result_r <= bus.div_result;
        dz_r     <= 1'b0;
        nv_r     <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.div_n      = hold_n;
  assign bus.div_d      = hold_d;
  assign bus.div_rm     = hold_rm;
  assign bus.div_op     = hold_op;
  assign bus.out_result = result_r;
  assign bus.out_dz     = dz_r;
  assign bus.out_nv     = nv_r;

endmodule
